// File: rtl/rx_frame_buffer_if.sv
// Byte-stream bundle between the deserialiser, the frame buffer and the frame consumer.
// The slave modport is the frame buffer's view; the master modport is the surrounding logic's view.
interface rx_frame_buffer_if;
    logic       in_soc;
    logic       in_eoc;
    logic       in_error;
    logic       in_data_valid;
    logic [7:0] in_data;
    logic [2:0] in_data_bits;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic [2:0] out_bits;
    logic       frame_dropped;
    logic       busy;

    modport slave (
        input  in_soc, in_eoc, in_error, in_data_valid, in_data, in_data_bits, out_ready,
        output out_valid, out_data, out_last, out_bits, frame_dropped, busy
    );

    modport master (
        output in_soc, in_eoc, in_error, in_data_valid, in_data, in_data_bits, out_ready,
        input  out_valid, out_data, out_last, out_bits, frame_dropped, busy
    );
endinterface

// File: rtl/rx_frame_buffer.sv
// Store-and-forward receive frame buffer: a frame is only released to the consumer once it
// has ended cleanly; errored, overflowing or empty frames are discarded with a one-cycle pulse.
module rx_frame_buffer #(
    parameter int DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    rx_frame_buffer_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, RX, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] rd_q, rd_d;
    logic          bad_q, bad_d;
    logic [2:0]    last_bits_q, last_bits_d;
    logic          drop_pend_q, drop_pend_d;
    logic          dropped_q, dropped_d;

    logic [7:0]    mem [DEPTH];
    logic          wr0_en, wr1_en;
    logic [AW-1:0] wr0_addr, wr1_addr;

    // Scratch values for the byte-then-partial-byte ordering inside one cycle
    logic [CW-1:0] cnt_a, cnt_b;
    logic          bad_a, bad_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rd_q        <= '0;
            bad_q       <= 1'b0;
            last_bits_q <= 3'd0;
            drop_pend_q <= 1'b0;
            dropped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_q        <= rd_d;
            bad_q       <= bad_d;
            last_bits_q <= last_bits_d;
            drop_pend_q <= drop_pend_d;
            dropped_q   <= dropped_d;
        end
    end

    // A coincident data byte and partial end byte land in two consecutive slots in one cycle.
    always_ff @(posedge clk) begin
        if (wr0_en) mem[wr0_addr] <= bus.in_data;
        if (wr1_en) mem[wr1_addr] <= bus.in_data;
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rd_d        = rd_q;
        bad_d       = bad_q;
        last_bits_d = last_bits_q;
        drop_pend_d = drop_pend_q;
        dropped_d   = 1'b0;
        wr0_en      = 1'b0;
        wr1_en      = 1'b0;
        wr0_addr    = count_q[AW-1:0];
        wr1_addr    = count_q[AW-1:0];
        cnt_a       = count_q;
        cnt_b       = count_q;
        bad_a       = bad_q;
        bad_b       = bad_q;

        unique case (state_q)
            IDLE: begin
                // A frame that started while draining still owes its drop pulse.
                if (drop_pend_q && bus.in_eoc) begin
                    dropped_d   = 1'b1;
                    drop_pend_d = 1'b0;
                end
                if (bus.in_soc) begin
                    state_d     = RX;
                    count_d     = '0;
                    bad_d       = 1'b0;
                    last_bits_d = 3'd0;
                    drop_pend_d = 1'b0;
                end
            end
            RX: begin
                if (bus.in_soc) begin
                    count_d     = '0;
                    bad_d       = 1'b0;
                    last_bits_d = 3'd0;
                end else begin
                    bad_a = bad_q | bus.in_error;
                    if (bus.in_data_valid) begin
                        if (count_q == FULL) begin
                            bad_a = 1'b1;
                        end else begin
                            wr0_en = 1'b1;
                            cnt_a  = count_q + CW'(1);
                        end
                    end
                    count_d = cnt_a;
                    bad_d   = bad_a;
                    if (bus.in_eoc) begin
                        cnt_b    = cnt_a;
                        bad_b    = bad_a;
                        wr1_addr = cnt_a[AW-1:0];
                        if (bus.in_data_bits != 3'd0) begin
                            if (cnt_a == FULL) begin
                                bad_b = 1'b1;
                            end else begin
                                wr1_en = 1'b1;
                                cnt_b  = cnt_a + CW'(1);
                            end
                        end
                        last_bits_d = bus.in_data_bits;
                        count_d     = cnt_b;
                        bad_d       = bad_b;
                        rd_d        = '0;
                        if (!bad_b && cnt_b != '0) begin
                            state_d = DRAIN;
                        end else begin
                            dropped_d = 1'b1;
                            state_d   = IDLE;
                        end
                    end
                end
            end
            DRAIN: begin
                if (bus.in_eoc && drop_pend_q) begin
                    dropped_d   = 1'b1;
                    drop_pend_d = 1'b0;
                end
                if (bus.in_soc) drop_pend_d = 1'b1;
                if (bus.out_ready) begin
                    if (rd_q == count_q - CW'(1)) begin
                        state_d = IDLE;
                        rd_d    = '0;
                    end else begin
                        rd_d = rd_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read is asynchronous so the next byte is ready the cycle after each acceptance.
    always_comb begin
        bus.out_valid     = (state_q == DRAIN);
        bus.out_last      = bus.out_valid && (rd_q == count_q - CW'(1));
        bus.out_data      = bus.out_valid ? mem[rd_q[AW-1:0]] : 8'h00;
        bus.out_bits      = bus.out_last ? last_bits_q : 3'd0;
        bus.frame_dropped = dropped_q;
        bus.busy          = (state_q != IDLE);
    end
endmodule

// File: tb/tb_rx_frame_buffer.sv
// Directed self-checking bench for rx_frame_buffer; one linear stimulus sequence with
// hand-computed expectations, outputs sampled 1 time unit after each rising edge.
module tb_rx_frame_buffer;
    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    int   nd;

    rx_frame_buffer_if bus ();

    rx_frame_buffer #(.DEPTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("[TB] check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.in_soc        = 1'b0;
        bus.in_eoc        = 1'b0;
        bus.in_error      = 1'b0;
        bus.in_data_valid = 1'b0;
        bus.in_data       = 8'h00;
        bus.in_data_bits  = 3'd0;
    endtask

    task automatic send_soc();
        bus.in_soc = 1'b1;
        tick();
        clear_in();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.in_data_valid = 1'b1;
        bus.in_data       = b;
        tick();
        clear_in();
    endtask

    task automatic send_eoc(input logic [7:0] d, input logic [2:0] bits);
        bus.in_eoc       = 1'b1;
        bus.in_data      = d;
        bus.in_data_bits = bits;
        tick();
        clear_in();
    endtask

    initial begin
        clear_in();
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #3;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_data", bus.out_data, 8'h00);
        chk("rst_dropped", bus.frame_dropped, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Two full bytes, no partial byte
        bus.out_ready = 1'b1;
        send_soc();
        send_byte(8'h93);
        send_byte(8'h20);
        chk("t1_hold_valid", bus.out_valid, 0);
        send_eoc(8'h00, 3'd0);
        chk("t1_valid", bus.out_valid, 1);
        chk("t1_data0", bus.out_data, 8'h93);
        chk("t1_last0", bus.out_last, 0);
        chk("t1_busy", bus.busy, 1);
        tick();
        chk("t1_data1", bus.out_data, 8'h20);
        chk("t1_last1", bus.out_last, 1);
        chk("t1_bits1", bus.out_bits, 0);
        tick();
        chk("t1_done", bus.out_valid, 0);
        chk("t1_idle", bus.busy, 0);

        // Partial-only frame of 7 bits
        bus.out_ready = 1'b0;
        send_soc();
        send_eoc(8'h26, 3'd7);
        chk("t2_valid", bus.out_valid, 1);
        chk("t2_data", bus.out_data, 8'h26);
        chk("t2_last", bus.out_last, 1);
        chk("t2_bits", bus.out_bits, 7);
        tick();
        chk("t2_hold", bus.out_data, 8'h26);
        bus.out_ready = 1'b1;
        tick();
        chk("t2_done", bus.out_valid, 0);

        // Errored frame
        send_soc();
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        bus.in_error = 1'b1;
        tick();
        clear_in();
        send_eoc(8'h00, 3'd0);
        chk("t3_dropped", bus.frame_dropped, 1);
        chk("t3_valid", bus.out_valid, 0);
        tick();
        chk("t3_pulse_end", bus.frame_dropped, 0);
        chk("t3_busy", bus.busy, 0);
        chk("t3_valid2", bus.out_valid, 0);

        // Overflow by one byte, then a good frame straight after
        send_soc();
        for (int i = 0; i < 17; i++) send_byte(8'(i + 8'h40));
        send_eoc(8'h00, 3'd0);
        chk("t4_dropped", bus.frame_dropped, 1);
        chk("t4_valid", bus.out_valid, 0);
        send_soc();
        chk("t4_pulse_end", bus.frame_dropped, 0);
        send_byte(8'hA5);
        send_byte(8'h5A);
        send_eoc(8'h00, 3'd0);
        chk("t4_data0", bus.out_data, 8'hA5);
        chk("t4_last0", bus.out_last, 0);
        tick();
        chk("t4_data1", bus.out_data, 8'h5A);
        chk("t4_last1", bus.out_last, 1);
        tick();
        chk("t4_done", bus.out_valid, 0);

        // Back-pressure while a second frame arrives
        bus.out_ready = 1'b0;
        send_soc();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_eoc(8'h00, 3'd0);
        chk("t5_data0", bus.out_data, 8'h11);
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) bus.in_soc = 1'b1;
            if (i == 1) begin
                bus.in_data_valid = 1'b1;
                bus.in_data       = 8'h44;
            end
            if (i == 2) bus.in_eoc = 1'b1;
            tick();
            clear_in();
            if (bus.frame_dropped) nd++;
            if (i % 3 == 0) begin
                chk("t5_stable", bus.out_data, 8'h11);
                chk("t5_stvalid", bus.out_valid, 1);
            end
        end
        chk("t5_dropcount", nd, 1);
        chk("t5_last_held", bus.out_last, 0);
        bus.out_ready = 1'b1;
        tick();
        chk("t5_data1", bus.out_data, 8'h22);
        tick();
        chk("t5_data2", bus.out_data, 8'h33);
        chk("t5_last2", bus.out_last, 1);
        tick();
        chk("t5_done", bus.out_valid, 0);

        // Reset mid-drain, stray eoc, then a normal frame
        bus.out_ready = 1'b0;
        send_soc();
        send_byte(8'h77);
        send_byte(8'h88);
        send_eoc(8'h00, 3'd0);
        chk("t6_valid", bus.out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rvalid", bus.out_valid, 0);
        chk("t6_rdata", bus.out_data, 8'h00);
        chk("t6_rlast", bus.out_last, 0);
        chk("t6_rbits", bus.out_bits, 0);
        chk("t6_rbusy", bus.busy, 0);
        tick();
        chk("t6_rdrop", bus.frame_dropped, 0);
        tick();
        rst_n = 1'b1;
        tick();
        send_eoc(8'h5A, 3'd3);
        chk("t6_stray_busy", bus.busy, 0);
        chk("t6_stray_valid", bus.out_valid, 0);
        chk("t6_stray_drop", bus.frame_dropped, 0);
        bus.out_ready = 1'b1;
        send_soc();
        send_byte(8'hC3);
        send_eoc(8'h00, 3'd0);
        chk("t6_data", bus.out_data, 8'hC3);
        chk("t6_last", bus.out_last, 1);
        chk("t6_bits", bus.out_bits, 0);
        tick();
        chk("t6_done", bus.out_valid, 0);

        // Data byte and partial byte in the same cycle as eoc
        bus.out_ready = 1'b0;
        send_soc();
        bus.in_data_valid = 1'b1;
        bus.in_eoc        = 1'b1;
        bus.in_data       = 8'h05;
        bus.in_data_bits  = 3'd3;
        tick();
        clear_in();
        chk("t7_data0", bus.out_data, 8'h05);
        chk("t7_last0", bus.out_last, 0);
        bus.out_ready = 1'b1;
        tick();
        chk("t7_data1", bus.out_data, 8'h05);
        chk("t7_last1", bus.out_last, 1);
        chk("t7_bits1", bus.out_bits, 3);
        tick();
        chk("t7_done", bus.out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rx_frame_buffer.md
RX_FRAME_BUFFER -- requirements
Module: rx_frame_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the frame store size in bytes (power of 2, 4..64).
REQ-002 SHALL have port clk  input  1  system clock (13.56 MHz); all logic is on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_soc  input  1  single-cycle pulse for start of frame, from the byte-wide rx path (deserialiser output).
REQ-005 SHALL have port in_eoc  input  1  single-cycle pulse for end of frame.
REQ-006 SHALL have port in_error  input  1  single-cycle pulse flagging a decode error in the current frame.
REQ-007 SHALL have port in_data_valid  input  1  single-cycle pulse marking in_data as a complete byte.
REQ-008 SHALL have port in_data  input  8  byte data, LSB first-received; also carries the partial byte when in_eoc=1.
REQ-009 SHALL have port in_data_bits  input  3  valid bits of the partial byte at in_eoc; 0 means no partial byte.
REQ-010 SHALL have port out_valid  output  1  out_data holds a byte of a released frame.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the byte when out_valid=1.
REQ-012 SHALL have port out_data  output  8  buffered byte.
REQ-013 SHALL have port out_last  output  1  out_data is the final byte of the frame.
REQ-014 SHALL have port out_bits  output  3  valid bits of the final byte (0 = 8); 0 when out_last=0.
REQ-015 SHALL have port frame_dropped  output  1  single-cycle pulse when a frame is discarded.
REQ-016 SHALL have port busy  output  1  high in RX and DRAIN states.

Function
REQ-017 SHALL be store-and-forward: no byte of a frame is presented until its in_eoc has been received with no error.
REQ-018 SHALL implement states IDLE, RX and DRAIN.
REQ-019 SHALL, in IDLE, move to RX on in_soc, with byte count=0 and bad flag=0.
REQ-020 SHALL, in RX, write in_data to mem[count] and increment count on in_data_valid.
REQ-021 SHALL, in RX, set the bad flag on in_error, and also on in_data_valid when count==DEPTH (overflow; the byte is not written).
REQ-022 SHALL, in RX, treat in_eoc with in_data_bits!=0 as one extra final byte: stored, with last_bits=in_data_bits; this byte sets bad if count==DEPTH.
REQ-023 SHALL, at in_eoc, go to DRAIN if not bad and total bytes >0; otherwise pulse frame_dropped for one cycle and go to IDLE.
REQ-024 SHALL restart the frame on in_soc while in RX: count=0, bad=0, no frame_dropped pulse.
REQ-025 SHALL, when in_data_valid and in_eoc coincide, store the byte first and then process in_eoc; an in_eoc partial byte then follows it.
REQ-026 SHALL assert out_valid the cycle after in_eoc is accepted (latency 1) and hold it high throughout DRAIN.
REQ-027 SHALL, in DRAIN, drive out_data=mem[rd]; out_last=1 when rd==count-1; out_bits=last_bits when out_last=1, else 0.
REQ-028 SHALL hold out_data, out_last and out_bits stable while out_valid=1 and out_ready=0.
REQ-029 SHALL increment rd on out_valid&&out_ready, and go to IDLE with rd=0 on acceptance of the last byte; out_valid SHALL be 0 the following cycle.
REQ-030 SHALL ignore in_soc received during DRAIN, pulsing frame_dropped once at the matching in_eoc; in_data_valid, in_error and in_eoc are also ignored in DRAIN apart from that pulse.
REQ-031 SHALL ignore in_data_valid, in_error and in_eoc received in IDLE.
REQ-032 SHALL use count and rd widths of $clog2(DEPTH)+1.

Reset
REQ-033 SHALL, while rst_n=0, force state=IDLE, count=0, rd=0, bad=0, last_bits=0, out_valid=0, out_last=0, out_bits=0, out_data=0, frame_dropped=0 and busy=0; memory contents need not be reset.
REQ-034 SHALL, on reset mid-RX or mid-DRAIN, discard the frame with no frame_dropped pulse.
REQ-035 SHALL leave RX and DRAIN with an in_eoc-free resume: after rst_n rises, a stray in_eoc in IDLE SHALL have no effect.

Verification
REQ-036 Bench SHALL cover: soc, bytes 0x93,0x20, eoc bits=0, out_ready=1 -> out 0x93 (last=0), then 0x20 (last=1, bits=0); out_valid one cycle after eoc.
REQ-037 Bench SHALL cover: soc, eoc with data=0x26 and bits=7 -> single byte 0x26, last=1, bits=7.
REQ-038 Bench SHALL cover: soc, 3 bytes, error, eoc -> frame_dropped pulse, out_valid never asserted, busy=0 after.
REQ-039 Bench SHALL cover: DEPTH+1 bytes then eoc -> frame_dropped; an immediately following valid 2-byte frame is delivered intact.
REQ-040 Bench SHALL cover: out_ready held 0 for 10 cycles during DRAIN while a second frame arrives -> first frame's data held stable, second frame dropped, then first frame completes.
REQ-041 Bench SHALL cover: rst_n pulsed low mid-DRAIN -> all outputs at reset values and no frame_dropped; the next frame is delivered normally.
